// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: 2-entry skid buffer, architectural flags, branch evaluation.
module alu_wb_stage #(
   parameter int unsigned DW      = 16,
   parameter int unsigned AW      = 3,
   parameter logic [3:0]  INON_OP = 4'b1111
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [DW-1:0] ALU_RES,
   input  logic [3:0]    FLAG_IN,
   input  logic [3:0]    S_ALU,
   input  logic [AW-1:0] WB_ADDR,
   input  logic          WB_EN,
   input  logic          FLUSH,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [DW-1:0] RESULT,
   output logic [AW-1:0] RD_ADDR,
   output logic          RD_WE,
   output logic [3:0]    FLAG_REG,
   input  logic [2:0]    COND,
   output logic          BR_TAKEN
);

   typedef struct packed {
      logic [DW-1:0] data;
      logic [AW-1:0] addr;
      logic          we;
   } entry_t;

   entry_t     head_q, head_d;
   entry_t     skid_q, skid_d;
   entry_t     in_entry;
   logic       head_valid_q, head_valid_d;
   logic       skid_valid_q, skid_valid_d;
   logic       in_ready_q, in_ready_d;
   logic       rd_we_q, rd_we_d;
   logic [3:0] flag_q, flag_d;
   logic       in_fire;
   logic       out_fire;

   assign in_entry = '{data: ALU_RES, addr: WB_ADDR, we: WB_EN};
   assign in_fire  = IN_VALID & in_ready_q;
   assign out_fire = head_valid_q & OUT_READY;

   // Next-state: skid has priority over a new input when refilling the head.
   always_comb begin
      head_d       = head_q;
      skid_d       = skid_q;
      head_valid_d = head_valid_q;
      skid_valid_d = skid_valid_q;
      flag_d       = flag_q;
      if (FLUSH) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         if (!head_valid_q || out_fire) begin
            if (skid_valid_q) begin
               head_d       = skid_q;
               head_valid_d = 1'b1;
               skid_valid_d = in_fire;
               if (in_fire) begin
                  skid_d = in_entry;
               end
            end else if (in_fire) begin
               head_d       = in_entry;
               head_valid_d = 1'b1;
            end else begin
               head_valid_d = 1'b0;
            end
         end else if (in_fire) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
         end
         if (in_fire && (S_ALU != INON_OP)) begin
            flag_d = FLAG_IN;
         end
      end
      in_ready_d = !skid_valid_d;
      rd_we_d    = head_valid_d & head_d.we;
   end

   // State registers; reset clears all entries and flags immediately.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         head_q       <= '0;
         skid_q       <= '0;
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         rd_we_q      <= 1'b0;
         flag_q       <= 4'b0000;
      end else begin
         head_q       <= head_d;
         skid_q       <= skid_d;
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         rd_we_q      <= rd_we_d;
         flag_q       <= flag_d;
      end
   end

   // Branch condition from the current flags {S,Z,C,V}.
   always_comb begin
      BR_TAKEN = 1'b0;
      unique case (COND)
         3'b000:  BR_TAKEN = 1'b1;
         3'b001:  BR_TAKEN = flag_q[2];
         3'b010:  BR_TAKEN = !flag_q[2];
         3'b011:  BR_TAKEN = flag_q[3] ^ flag_q[0];
         3'b100:  BR_TAKEN = !(flag_q[3] ^ flag_q[0]);
         3'b101:  BR_TAKEN = flag_q[1];
         3'b110:  BR_TAKEN = !flag_q[1];
         default: BR_TAKEN = 1'b0;
      endcase
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = head_valid_q;
   assign RESULT    = head_q.data;
   assign RD_ADDR   = head_q.addr;
   assign RD_WE     = rd_we_q;
   assign FLAG_REG  = flag_q;

endmodule
